if_fetch_ctrl: RTL and testbench

//   Sequences instruction fetch: owns the architectural fetch PC, issues one request at a time to instruction memory

---
 rtl/if_fetch_ctrl_pkg.sv | 18 +
 rtl/if_inst_buf.sv | 45 ++++
 rtl/if_fetch_ctrl.sv | 103 ++++++++++
 tb/tb_if_fetch_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/if_fetch_ctrl_pkg.sv
// rtl/if_fetch_ctrl_pkg.sv - shared widths, PC step and fetch FSM state encoding
package if_fetch_ctrl_pkg;

    localparam int CPU_WIDTH  = 32;
    localparam int INST_W_DEF = 32;
    localparam logic [CPU_WIDTH-1:0] PC_STEP = CPU_WIDTH'(4);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } if_state_e;

    function automatic logic [CPU_WIDTH-1:0] next_seq_pc(input logic [CPU_WIDTH-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/if_inst_buf.sv
// rtl/if_inst_buf.sv - one-entry valid/ready holding register for {inst, pc} with flush
module if_inst_buf #(
    parameter int INST_W = 32,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [INST_W-1:0] wr_inst,
    input  logic [PC_W-1:0]   wr_pc,
    output logic              valid,
    input  logic              ready,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   pc
);

    logic              valid_q;
    logic [INST_W-1:0] inst_q;
    logic [PC_W-1:0]   pc_q;

    // Flush wins over both fill and pop so a wrong-path entry can never be consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (wr_en) begin
            valid_q <= 1'b1;
            inst_q  <= wr_inst;
            pc_q    <= wr_pc;
        end else if (valid_q && ready) begin
            valid_q <= 1'b0;
        end
    end

    assign valid = valid_q;
    assign inst  = inst_q;
    assign pc    = pc_q;

    a_no_fill_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && valid_q));

endmodule

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - fetch sequencer: owns fetch PC, one outstanding imem request, redirect flush
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [CPU_WIDTH-1:0] RESET_PC = '0,
    parameter int                   INST_W   = INST_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 redirect,
    input  logic [CPU_WIDTH-1:0] redirect_pc,
    output logic                 imem_req,
    output logic [CPU_WIDTH-1:0] imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [INST_W-1:0]    imem_rdata,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [INST_W-1:0]    inst,
    output logic [CPU_WIDTH-1:0] inst_pc
);

    if_state_e              state_q, state_d;
    logic [CPU_WIDTH-1:0]   pc_q, pc_d;
    logic [CPU_WIDTH-1:0]   ofs_pc_q;
    logic                   issue;
    logic                   buf_wr;

    // Issuing only when the buffer is empty or draining guarantees room for the response.
    assign imem_req  = rst_n && (state_q == S_REQ) && ena && !redirect && (!inst_valid || inst_ready);
    assign imem_addr = pc_q;
    assign issue     = imem_req && imem_gnt;
    assign buf_wr    = (state_q == S_WAIT) && imem_rvalid && !redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            ofs_pc_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (issue) begin
                ofs_pc_q <= pc_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;

        if (redirect) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d = next_seq_pc(pc_q);
        end

        unique case (state_q)
            S_REQ: begin
                if (issue) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end else if (redirect) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    if_inst_buf #(
        .INST_W (INST_W),
        .PC_W   (CPU_WIDTH)
    ) u_inst_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (redirect),
        .wr_en   (buf_wr),
        .wr_inst (imem_rdata),
        .wr_pc   (ofs_pc_q),
        .valid   (inst_valid),
        .ready   (inst_ready),
        .inst    (inst),
        .pc      (inst_pc)
    );

    a_rvalid_only_when_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        !((state_q == S_REQ) && imem_rvalid));

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - table-driven self-checking bench for if_fetch_ctrl
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        ena;
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_inst;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    if_fetch_ctrl #(
        .RESET_PC (32'h0000_0080),
        .INST_W   (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic v(input logic e, input logic r, input logic [31:0] rpc, input logic g,
                     input logic rv, input logic [31:0] rd, input logic rdy,
                     input logic xreq, input logic [31:0] xaddr, input logic xval,
                     input logic [31:0] xinst, input logic [31:0] xpc);
        vec_t t;
        t.ena = e; t.redirect = r; t.redirect_pc = rpc; t.gnt = g; t.rvalid = rv;
        t.rdata = rd; t.ready = rdy; t.exp_req = xreq; t.exp_addr = xaddr;
        t.exp_valid = xval; t.exp_inst = xinst; t.exp_pc = xpc;
        vecs.push_back(t);
    endtask

    initial begin
        // sequential fetch with one-cycle memory latency, then decode stall
        v(1,0,0,1,0,0,1,            1,32'h80,0,0,0);
        v(1,0,0,1,1,32'hA0,1,       0,32'h84,0,0,0);
        v(1,0,0,1,0,0,1,            1,32'h84,1,32'hA0,32'h80);
        v(1,0,0,1,1,32'hA1,1,       0,32'h88,0,0,0);
        v(1,0,0,1,0,0,1,            1,32'h88,1,32'hA1,32'h84);
        v(1,0,0,1,1,32'hA2,1,       0,32'h8C,0,0,0);
        for (int i = 0; i < 5; i++)
            v(1,0,0,1,0,0,0,        0,32'h8C,1,32'hA2,32'h88);
        v(1,0,0,1,0,0,1,            1,32'h8C,1,32'hA2,32'h88);
        // redirect while waiting; late 0xDEAD must be dropped
        v(1,1,32'h200,1,0,0,1,      0,32'h90,0,0,0);
        v(1,0,0,1,0,0,1,            0,32'h200,0,0,0);
        v(1,0,0,1,0,0,1,            0,32'h200,0,0,0);
        v(1,0,0,1,1,32'hDEAD,1,     0,32'h200,0,0,0);
        v(1,0,0,1,0,0,1,            1,32'h200,0,0,0);
        v(1,0,0,1,1,32'hB0,1,       0,32'h204,0,0,0);
        v(1,0,0,1,0,0,1,            1,32'h204,1,32'hB0,32'h200);
        // redirect coinciding with rvalid
        v(1,1,32'h300,1,1,32'hB1,1, 0,32'h208,0,0,0);
        v(1,0,0,1,0,0,1,            1,32'h300,0,0,0);
        // ena low with a request outstanding
        v(0,0,0,1,0,0,1,            0,32'h304,0,0,0);
        v(0,0,0,1,1,32'hC0,1,       0,32'h304,0,0,0);
        v(0,0,0,1,0,0,0,            0,32'h304,1,32'hC0,32'h300);
        v(0,0,0,1,0,0,1,            0,32'h304,1,32'hC0,32'h300);
        v(0,0,0,1,0,0,1,            0,32'h304,0,0,0);
        v(1,0,0,1,0,0,1,            1,32'h304,0,0,0);
        v(1,0,0,1,1,32'hC1,1,       0,32'h308,0,0,0);
        v(1,0,0,0,0,0,1,            1,32'h308,1,32'hC1,32'h304);
        v(1,0,0,0,0,0,1,            1,32'h308,0,0,0);
        // back-to-back redirects in S_REQ, then wrap at top of address space
        v(1,1,32'hFFFF_FFF0,1,0,0,1, 0,32'h308,0,0,0);
        v(1,1,32'hFFFF_FFFC,1,0,0,1, 0,32'hFFFF_FFF0,0,0,0);
        v(1,0,0,1,0,0,1,            1,32'hFFFF_FFFC,0,0,0);
        v(1,0,0,1,0,0,1,            0,32'h0,0,0,0);

        rst_n = 1'b0; ena = 1'b1; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_req",   32'(imem_req),   32'h0);
        chk("reset_addr",  imem_addr,       32'h80);
        chk("reset_valid", 32'(inst_valid), 32'h0);
        chk("reset_inst",  inst,            32'h0);
        chk("reset_pc",    inst_pc,         32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            ena = vecs[i].ena; redirect = vecs[i].redirect; redirect_pc = vecs[i].redirect_pc;
            imem_gnt = vecs[i].gnt; imem_rvalid = vecs[i].rvalid; imem_rdata = vecs[i].rdata;
            inst_ready = vecs[i].ready;
            #1;
            chk($sformatf("row%0d_req", i),   32'(imem_req),   32'(vecs[i].exp_req));
            chk($sformatf("row%0d_addr", i),  imem_addr,       vecs[i].exp_addr);
            chk($sformatf("row%0d_valid", i), 32'(inst_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                chk($sformatf("row%0d_inst", i), inst,    vecs[i].exp_inst);
                chk($sformatf("row%0d_ipc", i),  inst_pc, vecs[i].exp_pc);
            end
        end

        // async reset while waiting for a response; late rvalid during reset is ignored
        @(negedge clk);
        ena = 1'b1; redirect = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req",   32'(imem_req),   32'h0);
        chk("midrst_addr",  imem_addr,       32'h80);
        chk("midrst_valid", 32'(inst_valid), 32'h0);
        chk("midrst_inst",  inst,            32'h0);
        chk("midrst_pc",    inst_pc,         32'h0);
        @(negedge clk);
        imem_rvalid = 1'b1; imem_rdata = 32'hEE;
        @(negedge clk);
        imem_rvalid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("postrst_req",  32'(imem_req),   32'h1);
        chk("postrst_addr", imem_addr,       32'h80);
        @(negedge clk);
        #1;
        chk("postrst_valid", 32'(inst_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
